dcsg_write_sequencer: RTL and testbench
=======================================

Name: dcsg_write_sequencer

Overview:
- Bus initiator that drains queued DCSG register writes onto the I/O bus as single write transactions.
- Commands enter a FIFO. Each entry selects DCSG port 0 or 1 and carries one data byte.
- Each entry is issued with a valid/ready handshake. A programmable minimum gap follows each write, counted in PSG enable ticks.
- Sits between a playback or CPU-side command source and the dual DCSG bus responder.

Parameters:
- FIFO_DEPTH_LOG2, 4: FIFO depth = 2^FIFO_DEPTH_LOG2 entries.
- GAP_TICKS, 32: minimum enable ticks after each completed write before the next; 0 = no gap.
- PORT0_ADDR, 8'h7E: I/O address driven for cmd_port = 0.
- PORT1_ADDR, 8'h7F: I/O address driven for cmd_port = 1.
- TIMEOUT_CYCLES, 255: clk cycles to wait for bus_ready before aborting; 8-bit range, must be 1..255.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- enable  input  1  PSG clock enable; gap counter advances only on cycles with enable = 1
- cmd_valid  input  1  command offered
- cmd_ready  output  1  FIFO can accept a command
- cmd_port  input  1  target DCSG select: 0 = PORT0_ADDR, 1 = PORT1_ADDR
- cmd_data  input  8  register write byte
- bus_ioreq  output  1  I/O-space request
- bus_address  output  8  I/O address
- bus_write  output  1  write strobe
- bus_valid  output  1  transaction valid
- bus_ready  input  1  responder accept
- bus_wdata  output  8  write data
- busy  output  1  FIFO non-empty or FSM not in IDLE
- err_timeout  output  1  sticky flag: a write was aborted
- err_clear  input  1  clears err_timeout

Behaviour:
- Reset (asynchronous, active-high):
  - FIFO emptied; FSM goes to IDLE.
  - bus_ioreq, bus_write, bus_valid, busy and err_timeout = 0; bus_address and bus_wdata = 8'h00.
  - cmd_ready = 0 while reset is high, and 1 on the first cycle after release.
- Command input:
  - Push occurs when cmd_valid & cmd_ready.
  - cmd_ready = ~full, taken from registered occupancy, so there is no push into a full FIFO.
  - Push and pop in the same cycle are allowed whenever the FIFO is not full.
- FSM state IDLE:
  - If the FIFO is non-empty: pop the head; register the address (chosen by cmd_port) and the data; go to REQ.
- FSM state REQ:
  - bus_ioreq = bus_write = bus_valid = 1; bus_address and bus_wdata are held stable.
  - On a rising edge with bus_valid & bus_ready: all three strobes go to 0 on the next cycle. Load the gap counter with GAP_TICKS and go to GAP, or go to IDLE if GAP_TICKS = 0.
- FSM state GAP:
  - Counter decrements on each cycle with enable = 1.
  - Reaching 0 moves the FSM to IDLE.
  - With enable stuck at 0, the FSM stays in GAP indefinitely.
- Latency:
  - Command accepted in cycle N; bus_valid first goes high in cycle N+2 (FIFO write, then IDLE pop).
  - Back-to-back writes with GAP_TICKS = 0: bus_valid is low for exactly 1 cycle between transactions.
- bus_address and bus_wdata keep their last values outside REQ. bus_write is never asserted without bus_valid.
- Timeout:
  - A cycle counter clears on entry to REQ.
  - If TIMEOUT_CYCLES cycles elapse in REQ without bus_ready, the write is dropped, the strobes drop, err_timeout is set, and the FSM proceeds exactly as for a completed write (gap included).
  - bus_ready in the same cycle as expiry counts as completion, with no error.
- err_clear:
  - Clears err_timeout.
  - A simultaneous set and clear leaves err_timeout = 1 (set wins).
- busy is registered and is 0 only when the FIFO is empty and the FSM is in IDLE.

Optional Feature:
- Macro: DCSG_WRITE_SEQUENCER_TIMEOUT_EN.
- Defined: the timeout counter and err_timeout behave as above.
- Undefined:
  - No counter is synthesized; REQ waits for bus_ready indefinitely.
  - err_timeout is tied to 0; err_clear is ignored.

Test Plan:
- Reset, then one push (port 0, data 8'h9F), with bus_ready tied to bus_valid -> bus_valid high 2 cycles after the push; bus_address = 8'h7E, bus_wdata = 8'h9F; busy falls after the gap.
- GAP_TICKS = 32, enable pulsed once every 4 clk, two pushes (port 1, data 8'h80 and 8'h05) -> the second bus_valid rises only after 32 enable ticks following the first handshake; second address = 8'h7F.
- Fill the FIFO with 16 commands while bus_ready = 0 -> cmd_ready = 0 after the 16th push; the 17th cmd_valid is not accepted; when bus_ready rises, all 16 are issued in order.
- bus_ready held 0 with the macro defined -> after 255 cycles the strobes drop and err_timeout = 1; the next command still issues; err_clear then returns err_timeout to 0.
- Assert reset while in REQ with 3 entries queued -> all outputs go to reset values immediately; the queued entries are lost; no bus_valid occurs after release.

Source files
------------

// File: rtl/dcsg_write_sequencer.sv
// dcsg_write_sequencer: drains a command FIFO of DCSG register writes onto the I/O bus with a post-write gap.
// Optional bus_ready timeout with sticky err_timeout when DCSG_WRITE_SEQUENCER_TIMEOUT_EN is defined.
module dcsg_write_sequencer #(
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int GAP_TICKS = 32,
  parameter logic [7:0] PORT0_ADDR = 8'h7E,
  parameter logic [7:0] PORT1_ADDR = 8'h7F,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_port,
  input  logic [7:0] cmd_data,
  output logic       bus_ioreq,
  output logic [7:0] bus_address,
  output logic       bus_write,
  output logic       bus_valid,
  input  logic       bus_ready,
  output logic [7:0] bus_wdata,
  output logic       busy,
  output logic       err_timeout,
  input  logic       err_clear
);
  localparam int AW = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 1 << AW;
  localparam int GW = GAP_TICKS > 0 ? $clog2(GAP_TICKS + 1) : 1;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} state_t;
  state_t r_state, w_state_nxt;
  logic [8:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0] r_count, w_count_nxt;
  logic r_cmd_ready, r_busy;
  logic [7:0] r_addr, r_wdata;
  logic [GW-1:0] r_gap, w_gap_nxt;
  logic w_push, w_pop, w_done, w_abort;

  assign w_push = cmd_valid & r_cmd_ready;
  assign w_pop = (r_state == S_IDLE) && (r_count != '0);
  assign w_done = (r_state == S_REQ) && (bus_ready || w_abort);
  assign w_count_nxt = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

`ifdef DCSG_WRITE_SEQUENCER_TIMEOUT_EN
  logic [7:0] r_tcnt;
  logic r_err;
  // bus_ready on the expiry cycle wins: w_done completes normally with no error
  assign w_abort = (r_state == S_REQ) && !bus_ready && (r_tcnt == 8'(TIMEOUT_CYCLES - 1));
  assign err_timeout = r_err;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tcnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_tcnt <= (r_state == S_REQ) ? r_tcnt + 8'd1 : 8'd0;
      r_err <= w_abort | (r_err & ~err_clear);
    end
  end
`else
  logic w_unused;
  assign w_unused = err_clear ^ (TIMEOUT_CYCLES == 0);
  assign w_abort = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt = r_gap;
    if (w_pop) begin
      w_state_nxt = S_REQ;
    end else if (w_done) begin
      w_state_nxt = GAP_TICKS == 0 ? S_IDLE : S_GAP;
      w_gap_nxt = GW'(GAP_TICKS);
    end else if (r_state == S_GAP && enable) begin
      w_gap_nxt = r_gap - GW'(1);
      w_state_nxt = r_gap == GW'(1) ? S_IDLE : S_GAP;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {cmd_port, cmd_data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count <= '0;
      r_cmd_ready <= 1'b0;
      r_busy <= 1'b0;
      r_addr <= 8'h00;
      r_wdata <= 8'h00;
      r_gap <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gap <= w_gap_nxt;
      r_count <= w_count_nxt;
      r_cmd_ready <= w_count_nxt != (AW+1)'(DEPTH);
      r_busy <= (w_count_nxt != '0) || (w_state_nxt != S_IDLE);
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_addr <= r_mem[r_rd_ptr][8] ? PORT1_ADDR : PORT0_ADDR;
        r_wdata <= r_mem[r_rd_ptr][7:0];
      end
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign busy = r_busy;
  assign bus_valid = r_state == S_REQ;
  assign bus_ioreq = bus_valid;
  assign bus_write = bus_valid;
  assign bus_address = r_addr;
  assign bus_wdata = r_wdata;
endmodule

// File: tb/tb_dcsg_write_sequencer.sv
// tb_dcsg_write_sequencer: table-driven and randomized checks against a transaction-order and gap-timing model.
module tb_dcsg_write_sequencer;
  localparam int GAP = 32;
  logic clk = 1'b0, reset, enable = 1'b0, cmd_valid, cmd_port, bus_ready, err_clear;
  logic [7:0] cmd_data, bus_address, bus_wdata;
  logic cmd_ready, bus_ioreq, bus_write, bus_valid, busy, err_timeout;
  int total = 0, bad = 0;
  int rmode, en_div, cyc = 0;
  logic rdrv;
  logic [15:0] expq[$];
  typedef struct {logic port; logic [7:0] data; logic [7:0] exp_addr;} vec_t;
  vec_t vt[16];

  dcsg_write_sequencer #(.GAP_TICKS(GAP)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_port(cmd_port), .cmd_data(cmd_data), .bus_ioreq(bus_ioreq), .bus_address(bus_address),
    .bus_write(bus_write), .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_wdata(bus_wdata),
    .busy(busy), .err_timeout(err_timeout), .err_clear(err_clear));

  always #5 clk = ~clk;
  assign bus_ready = rmode == 1 ? bus_valid : rdrv;

  always @(posedge clk) begin
    #1;
    cyc++;
    enable = en_div == 0 ? 1'b0 : en_div < 0 ? 1'($urandom_range(1)) : 1'(cyc % en_div == 0);
    if (rmode == 2) rdrv = 1'($urandom_range(1));
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  logic pv = 1'b0;
  bit have_hs = 0;
  int ticks = 0, last_ticks = -1, rises = 0;
  always @(negedge clk) begin
    if (reset) begin
      pv = 1'b0;
      have_hs = 0;
    end else begin
      if (bus_valid && !pv) begin
        rises++;
        if (have_hs) begin
          last_ticks = ticks;
          chk("gap_min", 32'(ticks >= GAP), 1);
        end
      end
      chk("strobes", {bus_ioreq, bus_write}, {bus_valid, bus_valid});
      if (bus_valid && bus_ready) begin
        if (expq.size() == 0) chk("unexpected_write", {bus_address, bus_wdata}, 32'hdead);
        else chk("write", {bus_address, bus_wdata}, expq.pop_front());
        have_hs = 1;
        ticks = 0;
      end else if (enable) ticks++;
      pv = bus_valid;
    end
  end

  task automatic push(input logic p, input logic [7:0] d, input logic [7:0] a, input bit exp);
    bit ok = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_port = p; cmd_data = d;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      ok = cmd_ready;
    end
    if (!ok) chk("push_timeout", 0, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (ok && exp) expq.push_back({a, d});
  endtask

  task automatic wait_idle(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (!busy && expq.size() == 0) return;
    end
    chk("idle_timeout", {16'(expq.size()), 15'd0, busy}, 0);
  endtask

  task automatic wait_valid(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (bus_valid) return;
    end
    chk("valid_timeout", 0, 1);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, r0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_port = 1'b0; cmd_data = 8'h00; err_clear = 1'b0;
    rmode = 1; rdrv = 1'b0; en_div = 1;
    for (int i = 0; i < 16; i++) begin
      vt[i].port = 1'(i * 5 >> 1);
      vt[i].data = 8'(8'h10 + i * 37);
      vt[i].exp_addr = vt[i].port ? 8'h7F : 8'h7E;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_strobes", {bus_ioreq, bus_write, bus_valid}, 0);
    chk("rst_addr_data", {bus_address, bus_wdata}, 0);
    chk("rst_busy_err", {busy, err_timeout}, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rel_cmd_ready", cmd_ready, 1);

    push(1'b0, 8'h9F, 8'h7E, 1);
    @(negedge clk); chk("lat_n1_valid", bus_valid, 0);
    @(negedge clk); chk("lat_n2_valid", bus_valid, 1);
    chk("lat_n2_addr_data", {bus_address, bus_wdata}, 16'h7E9F);
    @(negedge clk); chk("gap_busy", {busy, bus_valid}, 2'b10);
    wait_idle(200);

    en_div = 4;
    push(1'b1, 8'h80, 8'h7F, 1);
    push(1'b1, 8'h05, 8'h7F, 1);
    wait_idle(1000);
    chk("gap_exact", last_ticks, GAP);

    en_div = 1;
    push(1'b0, 8'h33, 8'h7E, 1);
    en_div = 0;
    repeat (3) @(negedge clk);
    rmode = 0;
    for (int i = 0; i < 16; i++) push(vt[i].port, vt[i].data, vt[i].exp_addr, 1);
    @(negedge clk); chk("full_ready", cmd_ready, 0);
    @(posedge clk); #1 cmd_valid = 1'b1; cmd_data = 8'hAA;
    n = 0;
    repeat (6) begin @(negedge clk); n += int'(cmd_ready); end
    @(posedge clk); #1 cmd_valid = 1'b0;
    chk("full_no_accept", n, 0);
    chk("gap_stuck", {busy, bus_valid}, 2'b10);
    rmode = 1; en_div = 1;
    wait_idle(4000);

`ifdef DCSG_WRITE_SEQUENCER_TIMEOUT_EN
    rmode = 0;
    push(1'b1, 8'hC3, 8'h7F, 0);
    wait_valid(10);
    n = 1;
    for (int i = 0; i < 600 && bus_valid; i++) begin @(negedge clk); n += int'(bus_valid); end
    chk("timeout_len", n, 255);
    chk("timeout_err", err_timeout, 1);
    rmode = 1;
    push(1'b0, 8'h5A, 8'h7E, 1);
    wait_idle(500);
    chk("err_sticky", err_timeout, 1);
    @(posedge clk); #1 err_clear = 1'b1;
    @(posedge clk); #1 err_clear = 1'b0;
    @(negedge clk); chk("err_cleared", err_timeout, 0);
`else
    rmode = 0;
    push(1'b1, 8'hC3, 8'h7F, 1);
    wait_valid(10);
    n = 0;
    repeat (300) begin @(negedge clk); n += int'(bus_valid); end
    chk("no_timeout_hold", n, 300);
    @(posedge clk); #1 err_clear = 1'b1;
    @(posedge clk); #1 err_clear = 1'b0;
    chk("no_timeout_err", err_timeout, 0);
    rmode = 1;
    wait_idle(500);
`endif

    rmode = 0;
    for (int i = 0; i < 4; i++) push(1'(i), 8'(8'hE0 + i), 8'h00, 0);
    @(negedge clk); chk("req_before_rst", {bus_valid, busy}, 2'b11);
    @(posedge clk); #2 reset = 1'b1;
    #1;
    chk("async_rst_strobes", {bus_ioreq, bus_write, bus_valid, cmd_ready}, 0);
    chk("async_rst_busy_err", {busy, err_timeout}, 0);
    chk("async_rst_addr_data", {bus_address, bus_wdata}, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    rmode = 1;
    r0 = rises;
    repeat (60) @(negedge clk);
    chk("no_write_after_rst", rises - r0, 0);
    chk("idle_after_rst", {busy, cmd_ready}, 2'b01);

    rmode = 2; en_div = -1;
    for (int i = 0; i < 120; i++) begin
      logic p;
      logic [7:0] d;
      p = 1'($urandom_range(1));
      d = 8'($urandom_range(255));
      repeat ($urandom_range(3)) @(posedge clk);
      push(p, d, p ? 8'h7F : 8'h7E, 1);
    end
    rmode = 1;
    wait_idle(20000);
    chk("rand_drained", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
